run_ctrl: RTL

//  Host-side run controller upstream of the processor top level. Preloads data memory
//  (jump-target LUT bytes at addr 1..4 plus operands) over a valid/ready byte stream.

---
 rtl/run_ctrl_pkg.sv | 19 +
 rtl/run_ctrl_sat_counter.sv | 24 ++
 rtl/run_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller and the benches that drive it.
// Address constants describe where the core expects its jump-target LUT in data memory.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        HOLD  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    // The core raises core_done when its PC reaches this value.
    localparam logic [7:0] DONE_PC  = 8'd128;
    localparam logic [7:0] LUT_BASE = 8'd1;
    localparam logic [7:0] LUT_LAST = 8'd4;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
// Latency: count visible the cycle after enable. No backpressure.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Host run controller: preloads data memory, holds the core in reset, then times its run.
// Latency: memory write one cycle after each accepted load byte; core released RST_CYC cycles after the last byte.
// Backpressure: ld_ready is high only in LOAD; bytes offered in any other state are not taken.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          AW      = 8,
    parameter int          CW      = 16,
    parameter int unsigned TIMEOUT = 32'hFFFF,
    parameter int          RST_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dat,
    output logic          core_rst,
    output logic          core_req,
    input  logic          core_done,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    localparam int HW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_t        state;
    state_t        next_state;
    logic [HW-1:0] hold_cnt;
    logic          xfer;
    logic          launch;
    logic          cnt_en;
    logic          go_run;
    logic          set_fin;
    logic          set_to;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        launch     = 1'b0;
        cnt_en     = 1'b0;
        go_run     = 1'b0;
        set_fin    = 1'b0;
        set_to     = 1'b0;
        xfer       = ld_valid && (state == LOAD);
        ld_ready   = (state == LOAD);
        core_rst   = (state != RUN);
        busy       = (state == LOAD) || (state == HOLD) || (state == RUN);
        case (state)
            IDLE, DONE, FAULT: begin
                if (start) begin
                    next_state = LOAD;
                    launch     = 1'b1;
                end
            end
            LOAD: begin
                if (xfer && ld_last) begin
                    next_state = HOLD;
                end
            end
            // Counting starts on the entry edge so the first RUN cycle already reads 1.
            HOLD: begin
                if (hold_cnt == '0) begin
                    next_state = RUN;
                    go_run     = 1'b1;
                    cnt_en     = 1'b1;
                end
            end
            RUN: begin
                if (core_done) begin
                    next_state = DONE;
                    set_fin    = 1'b1;
                end else if (cycles == CW'(TIMEOUT)) begin
                    next_state = FAULT;
                    set_to     = 1'b1;
                end else begin
                    cnt_en     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (state == LOAD) begin
            hold_cnt <= HW'(RST_CYC - 1);
        end else if ((state == HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_dat   <= '0;
        end else begin
            mem_wr_en <= xfer;
            if (xfer) begin
                mem_addr <= ld_addr;
                mem_dat  <= ld_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_req <= 1'b0;
            finished <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            core_req <= go_run;
            if (launch) begin
                finished <= 1'b0;
                timeout  <= 1'b0;
            end else begin
                if (set_fin) finished <= 1'b1;
                if (set_to)  timeout  <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CW)) u_cycles (
        .clk   (clk),
        .rst_n (reset),
        .clr   (launch),
        .en    (cnt_en),
        .q     (cycles)
    );

endmodule
